// File: rtl/libv_deque.sv
// libv_deque: ring-buffer double-ended queue, responder side of the deque command port.
// Ports:
//   clk, arst_n          clock and asynchronous active-low reset
//   flush                synchronous clear of contents (wins over any command)
//   cmd_vld/cmd/cmd_dat  command request; cmd_dat used by pushes only
//   cmd_rdy              combinational accept; command taken when cmd_vld & cmd_rdy
//   rsp_vld/rsp_dat      registered pop result, one-cycle pulse, data held otherwise
//   empty/full/cnt       registered occupancy status

package libv_pkg;
    typedef enum logic [1:0] {
        PUSH_FRONT = 2'b00,
        POP_FRONT  = 2'b01,
        PUSH_BACK  = 2'b10,
        POP_BACK   = 2'b11
    } cmd_t;
endpackage

module libv_deque
    import libv_pkg::*;
#(
    parameter int unsigned N = 4,
    parameter int unsigned W = 32
) (
    input  logic                     clk,
    input  logic                     arst_n,
    input  logic                     flush,
    input  logic                     cmd_vld,
    input  cmd_t                     cmd,
    input  logic [W-1:0]             cmd_dat,
    output logic                     cmd_rdy,
    output logic                     rsp_vld,
    output logic [W-1:0]             rsp_dat,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(N+1)-1:0]   cnt
);

    localparam int unsigned PW = (N > 1) ? $clog2(N) : 1;
    localparam int unsigned CW = $clog2(N + 1);
    localparam logic [PW-1:0] LAST_IDX = PW'(N - 1);
    localparam logic [CW-1:0] CNT_MAX  = CW'(N);

    logic [W-1:0]  r_mem [N];
    logic [PW-1:0] r_head, r_tail;
    logic [CW-1:0] r_cnt;
    logic          r_empty, r_full;
    logic          r_rsp_vld;
    logic [W-1:0]  r_rsp_dat;

    logic [PW-1:0] w_head_inc, w_head_dec, w_tail_inc, w_tail_dec;
    logic [PW-1:0] w_head_nxt, w_tail_nxt, w_wr_idx;
    logic [CW-1:0] w_cnt_nxt;
    logic          w_rsp_vld_nxt, w_wr_en;
    logic [W-1:0]  w_rsp_dat_nxt;
    logic          w_is_push, w_is_pop, w_acc;

    // Explicit wrap so N need not be a power of two
    assign w_head_inc = (r_head == LAST_IDX) ? '0 : r_head + PW'(1);
    assign w_head_dec = (r_head == '0) ? LAST_IDX : r_head - PW'(1);
    assign w_tail_inc = (r_tail == LAST_IDX) ? '0 : r_tail + PW'(1);
    assign w_tail_dec = (r_tail == '0) ? LAST_IDX : r_tail - PW'(1);

    assign w_is_push = (cmd == PUSH_FRONT) || (cmd == PUSH_BACK);
    assign w_is_pop  = !w_is_push;

    // Ready is high when idle so a producer can see readiness before asserting valid
    assign cmd_rdy = !flush && (!cmd_vld || (w_is_push && !r_full) || (w_is_pop && !r_empty));
    assign w_acc   = cmd_vld && cmd_rdy;

    // Next-state for pointers, occupancy, response and write port
    always_comb begin
        w_head_nxt    = r_head;
        w_tail_nxt    = r_tail;
        w_cnt_nxt     = r_cnt;
        w_rsp_vld_nxt = 1'b0;
        w_rsp_dat_nxt = r_rsp_dat;
        w_wr_en       = 1'b0;
        w_wr_idx      = r_tail;
        if (flush) begin
            w_head_nxt = '0;
            w_tail_nxt = '0;
            w_cnt_nxt  = '0;
        end else if (w_acc) begin
            unique case (cmd)
                PUSH_FRONT: begin
                    w_head_nxt = w_head_dec;
                    w_wr_en    = 1'b1;
                    w_wr_idx   = w_head_dec;
                    w_cnt_nxt  = r_cnt + CW'(1);
                end
                PUSH_BACK: begin
                    w_tail_nxt = w_tail_inc;
                    w_wr_en    = 1'b1;
                    w_wr_idx   = r_tail;
                    w_cnt_nxt  = r_cnt + CW'(1);
                end
                POP_FRONT: begin
                    w_head_nxt    = w_head_inc;
                    w_rsp_vld_nxt = 1'b1;
                    w_rsp_dat_nxt = r_mem[r_head];
                    w_cnt_nxt     = r_cnt - CW'(1);
                end
                POP_BACK: begin
                    w_tail_nxt    = w_tail_dec;
                    w_rsp_vld_nxt = 1'b1;
                    w_rsp_dat_nxt = r_mem[w_tail_dec];
                    w_cnt_nxt     = r_cnt - CW'(1);
                end
                default: ;
            endcase
        end
    end

    // Control and status registers
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            r_head    <= '0;
            r_tail    <= '0;
            r_cnt     <= '0;
            r_empty   <= 1'b1;
            r_full    <= 1'b0;
            r_rsp_vld <= 1'b0;
            r_rsp_dat <= '0;
        end else begin
            r_head    <= w_head_nxt;
            r_tail    <= w_tail_nxt;
            r_cnt     <= w_cnt_nxt;
            r_empty   <= (w_cnt_nxt == '0);
            r_full    <= (w_cnt_nxt == CNT_MAX);
            r_rsp_vld <= w_rsp_vld_nxt;
            r_rsp_dat <= w_rsp_dat_nxt;
        end
    end

    // Storage is not reset; only occupied slots are ever read
    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_mem[w_wr_idx] <= cmd_dat;
        end
    end

    assign rsp_vld = r_rsp_vld;
    assign rsp_dat = r_rsp_dat;
    assign empty   = r_empty;
    assign full    = r_full;
    assign cnt     = r_cnt;

    a_cnt_bound: assert property (@(posedge clk) disable iff (!arst_n) r_cnt <= CNT_MAX);
    a_no_push_full: assert property (@(posedge clk) disable iff (!arst_n)
        (w_acc && w_is_push) |-> !r_full);
    a_no_pop_empty: assert property (@(posedge clk) disable iff (!arst_n)
        (w_acc && w_is_pop) |-> !r_empty);
    // A stalled push that is still presented next cycle must carry the same data
    a_hold_stable: assert property (@(posedge clk) disable iff (!arst_n)
        (cmd_vld && !cmd_rdy && !flush && w_is_push)
        |=> (!cmd_vld || (cmd != $past(cmd)) || (cmd_dat == $past(cmd_dat))));

endmodule

// File: tb/tb_libv_deque.sv
module tb_libv_deque;
    import libv_pkg::*;

    localparam int unsigned N  = 4;
    localparam int unsigned W  = 32;
    localparam int unsigned CW = $clog2(N + 1);

    logic          clk     = 1'b0;
    logic          arst_n  = 1'b0;
    logic          flush   = 1'b0;
    logic          cmd_vld = 1'b0;
    cmd_t          cmd     = PUSH_BACK;
    logic [W-1:0]  cmd_dat = '0;
    logic          cmd_rdy;
    logic          rsp_vld;
    logic [W-1:0]  rsp_dat;
    logic          empty;
    logic          full;
    logic [CW-1:0] cnt;

    libv_deque #(.N(N), .W(W)) dut (
        .clk     (clk),
        .arst_n  (arst_n),
        .flush   (flush),
        .cmd_vld (cmd_vld),
        .cmd     (cmd),
        .cmd_dat (cmd_dat),
        .cmd_rdy (cmd_rdy),
        .rsp_vld (rsp_vld),
        .rsp_dat (rsp_dat),
        .empty   (empty),
        .full    (full),
        .cnt     (cnt)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] dat;
        int          cyc;
    } exp_t;
    exp_t exp_q[$];

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Scoreboard monitor: every response must match the oldest expectation in data and cycle
    always @(negedge clk) begin
        if (arst_n) begin
            if (rsp_vld === 1'b1) begin
                if (exp_q.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL rsp_unexpected: got rsp_dat 0x%0h expected no response (t=%0t)",
                             rsp_dat, $time);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("rsp_dat", rsp_dat, e.dat);
                    chk("rsp_cycle", 32'(cyc), 32'(e.cyc));
                end
            end else if (rsp_vld !== 1'b0) begin
                chk("rsp_vld_known", 32'(rsp_vld), 32'(0));
            end else if (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
                exp_t e;
                e = exp_q.pop_front();
                n_chk++;
                n_fail++;
                $display("FAIL rsp_missing: got no response expected rsp_dat 0x%0h (t=%0t)",
                         e.dat, $time);
            end
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Present one command for one cycle; queue the expected pop result if accepted
    task automatic send(input cmd_t op, input logic [31:0] dat, input logic exp_rdy,
                        input logic [31:0] exp_rsp, input string name);
        cmd_vld = 1'b1;
        cmd     = op;
        cmd_dat = dat;
        @(negedge clk);
        chk({name, "_rdy"}, 32'(cmd_rdy), 32'(exp_rdy));
        if (exp_rdy && (op == POP_FRONT || op == POP_BACK)) begin
            exp_q.push_back('{dat: exp_rsp, cyc: cyc + 1});
        end
        @(posedge clk);
        #1;
        cmd_vld = 1'b0;
    endtask

    task automatic chk_stat(input string name, input int exp_cnt);
        chk({name, "_cnt"},   32'(cnt),   32'(exp_cnt));
        chk({name, "_empty"}, 32'(empty), 32'(exp_cnt == 0));
        chk({name, "_full"},  32'(full),  32'(exp_cnt == int'(N)));
    endtask

    task automatic do_flush();
        flush = 1'b1;
        step(1);
        flush = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected end of test");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset state
        step(2);
        arst_n = 1'b1;
        chk_stat("por", 0);
        chk("por_rsp_vld", 32'(rsp_vld), 32'(0));
        chk("por_rsp_dat", rsp_dat, 32'h0);

        // 1: asynchronous reset in the middle of traffic
        send(PUSH_BACK, 32'h1, 1'b1, 32'h0, "t1_pb1");
        send(PUSH_BACK, 32'h2, 1'b1, 32'h0, "t1_pb2");
        chk_stat("t1_pre", 2);
        #2 arst_n = 1'b0;
        #1;
        chk_stat("t1_arst", 0);
        chk("t1_arst_rsp_vld", 32'(rsp_vld), 32'(0));
        @(posedge clk);
        #1 arst_n = 1'b1;
        cmd_vld = 1'b1;
        cmd     = PUSH_BACK;
        #1;
        chk("t1_rdy_pushback", 32'(cmd_rdy), 32'(1));
        cmd_vld = 1'b0;
        step(1);
        chk_stat("t1_post", 0);

        // 2: FIFO order through back pushes and front pops, back-to-back
        send(PUSH_BACK, 32'h11, 1'b1, 32'h0, "t2_pb11");
        send(PUSH_BACK, 32'h22, 1'b1, 32'h0, "t2_pb22");
        send(PUSH_BACK, 32'h33, 1'b1, 32'h0, "t2_pb33");
        chk_stat("t2_fill", 3);
        send(POP_FRONT, 32'h0, 1'b1, 32'h11, "t2_pf1");
        send(POP_FRONT, 32'h0, 1'b1, 32'h22, "t2_pf2");
        send(POP_FRONT, 32'h0, 1'b1, 32'h33, "t2_pf3");
        chk_stat("t2_drain", 0);
        step(1);

        // 3: front pushes starting at head 0 wrap to N-1
        do_flush();
        send(PUSH_FRONT, 32'hA, 1'b1, 32'h0, "t3_pfa");
        send(PUSH_FRONT, 32'hB, 1'b1, 32'h0, "t3_pfb");
        chk_stat("t3_fill", 2);
        send(POP_FRONT, 32'h0, 1'b1, 32'hB, "t3_popf");
        send(POP_BACK,  32'h0, 1'b1, 32'hA, "t3_popb");
        chk_stat("t3_drain", 0);
        step(1);

        // 4: fill from both ends, stall a push while full, then free a slot
        do_flush();
        send(PUSH_BACK,  32'h1, 1'b1, 32'h0, "t4_pb1");
        send(PUSH_BACK,  32'h2, 1'b1, 32'h0, "t4_pb2");
        send(PUSH_FRONT, 32'h3, 1'b1, 32'h0, "t4_pf3");
        send(PUSH_FRONT, 32'h4, 1'b1, 32'h0, "t4_pf4");
        chk_stat("t4_full", 4);
        cmd_vld = 1'b1;
        cmd     = PUSH_BACK;
        cmd_dat = 32'h5;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("t4_stall_rdy", 32'(cmd_rdy), 32'(0));
            @(posedge clk);
            #1;
        end
        chk_stat("t4_stalled", 4);
        send(POP_BACK,  32'h0, 1'b1, 32'h2, "t4_popb");
        send(PUSH_BACK, 32'h5, 1'b1, 32'h0, "t4_pb5");
        chk_stat("t4_refull", 4);
        send(POP_FRONT, 32'h0, 1'b1, 32'h4, "t4_pf_a");
        send(POP_FRONT, 32'h0, 1'b1, 32'h3, "t4_pf_b");
        send(POP_FRONT, 32'h0, 1'b1, 32'h1, "t4_pf_c");
        send(POP_FRONT, 32'h0, 1'b1, 32'h5, "t4_pf_d");
        chk_stat("t4_drain", 0);
        step(1);

        // 5: pop on empty stalls with no response, then a push is taken
        cmd_vld = 1'b1;
        cmd     = POP_FRONT;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("t5_empty_pop_rdy", 32'(cmd_rdy), 32'(0));
            @(posedge clk);
            #1;
        end
        chk_stat("t5_nochange", 0);
        send(PUSH_BACK, 32'h7, 1'b1, 32'h0, "t5_pb7");
        chk_stat("t5_one", 1);
        send(POP_FRONT, 32'h0, 1'b1, 32'h7, "t5_pf7");
        chk_stat("t5_drain", 0);
        step(1);

        // 6: flush beats a simultaneous pop
        send(PUSH_BACK, 32'h61, 1'b1, 32'h0, "t6_pb1");
        send(PUSH_BACK, 32'h62, 1'b1, 32'h0, "t6_pb2");
        send(PUSH_BACK, 32'h63, 1'b1, 32'h0, "t6_pb3");
        chk_stat("t6_fill", 3);
        flush   = 1'b1;
        cmd_vld = 1'b1;
        cmd     = POP_FRONT;
        @(negedge clk);
        chk("t6_flush_rdy", 32'(cmd_rdy), 32'(0));
        @(posedge clk);
        #1;
        flush   = 1'b0;
        cmd_vld = 1'b0;
        chk_stat("t6_flushed", 0);
        chk("t6_rsp_vld", 32'(rsp_vld), 32'(0));
        step(2);

        chk("sb_drained", 32'(exp_q.size()), 32'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
